// File: rtl/data_memory_responder_if.sv
// ============================================================================
// Module  : data_memory_responder_if
// Purpose : MEM-stage data-memory bus between the CPU pipeline (master) and
//           the multi-cycle data memory responder (slave).
// Signals : MemRead_i   load request, held until ack_o
//           MemWrite_i  store request, held until ack_o
//           addr_i      32-bit byte address
//           data_i      32-bit store data
//           data_o      32-bit registered load data
//           stall_o     pipeline freeze
//           ack_o       one-cycle completion pulse
//           err_o       error flag, meaningful only while ack_o=1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_memory_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    // CPU side
    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, stall_o, ack_o, err_o
    );

    // Memory side
    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, stall_o, ack_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/data_memory_responder.sv
// ============================================================================
// Module  : data_memory_responder
// Purpose : Multi-cycle data memory for the MEM stage. Accepts a load or
//           store in IDLE, spends LATENCY cycles in BUSY, then pulses ack for
//           one RESP cycle. Illegal requests (read+write, misaligned, out of
//           range) skip BUSY and are acked with err_o one cycle later.
// Ports   : clk_i    clock, rising edge
//           rst_n_i  asynchronous active-low reset
//           bus      data_memory_responder_if.slave (request/response bus)
// Params  : DEPTH    number of 32-bit words (>= 2)
//           LATENCY  BUSY cycles per valid access (1..15)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  wire logic              clk_i,
    input  wire logic              rst_n_i,
    data_memory_responder_if.slave bus
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    counter;
    logic          op_write;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          err_flag;
    logic [31:0]   data_q;

    logic [31:0]   mem [DEPTH];

    logic req;
    logic bad;
    logic mem_we;

    assign req = bus.MemRead_i | bus.MemWrite_i;
    assign bad = (bus.MemRead_i & bus.MemWrite_i)
               | (bus.addr_i[1:0] != 2'b00)
               | (bus.addr_i >= ADDR_LIMIT);

    // The store commits on the final BUSY edge. An asynchronous reset forces
    // the state to IDLE, so a store interrupted by reset never reaches here.
    assign mem_we = (state == BUSY) && (counter == 4'd0) && op_write;

    // Stall must rise in the very cycle the request appears (combinational
    // on req) and drop in RESP so the pipeline advances at the end of RESP.
    assign bus.stall_o = ((state == IDLE) && req) || (state == BUSY);
    assign bus.ack_o   = (state == RESP);
    assign bus.err_o   = (state == RESP) && err_flag;
    assign bus.data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            counter  <= 4'd0;
            op_write <= 1'b0;
            idx      <= '0;
            wdata    <= 32'd0;
            err_flag <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (bad) begin
                            err_flag <= 1'b1;
                            state    <= RESP;
                        end else begin
                            err_flag <= 1'b0;
                            op_write <= bus.MemWrite_i;
                            idx      <= bus.addr_i[AW+1:2];
                            wdata    <= bus.data_i;
                            counter  <= CNT_INIT;
                            state    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        if (!op_write) begin
                            data_q <= mem[idx];
                        end
                        state <= RESP;
                    end
                end
                // Inputs are still the same instruction here; ignore them.
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents intentionally survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module  : tb_data_memory_responder
// Purpose : Self-checking bench for data_memory_responder. Two instances:
//           dut3 (LATENCY=3) and dut1 (LATENCY=1), both DEPTH=32. A bench
//           model computes each transaction's expected ack cycle, stall
//           pattern, error flag and data_o; these are queued when the request
//           is driven and popped when the DUT acks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_memory_responder_if bus3 ();
    data_memory_responder_if bus1 ();

    data_memory_responder #(.DEPTH(32), .LATENCY(3)) dut3 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus3)
    );

    data_memory_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          ack_at;
        int          stall_mask;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } stim_t;

    exp_t        sb [$];
    logic [31:0] mdl_mem [logic [32:0]];
    logic [31:0] mdl_last [2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference behaviour: compute the expectation and push it to the queue.
    task automatic push_expect(input bit sel1, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   lat;
        logic is_bad;
        lat    = sel1 ? 1 : 3;
        is_bad = (rd & wr) | (a[1:0] != 2'b00) | (a >= 32'd128);
        if (is_bad) begin
            e.err        = 1'b1;
            e.ack_at     = 1;
            e.stall_mask = 1;
        end else begin
            e.err        = 1'b0;
            e.ack_at     = lat + 1;
            e.stall_mask = (1 << (lat + 1)) - 1;
            if (wr) mdl_mem[{sel1, a}] = d;
            if (rd) mdl_last[sel1] = mdl_mem.exists({sel1, a}) ? mdl_mem[{sel1, a}] : 32'd0;
        end
        e.data = mdl_last[sel1];
        sb.push_back(e);
    endtask

    task automatic drive(input bit sel1, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel1) begin
            bus1.MemRead_i = rd; bus1.MemWrite_i = wr; bus1.addr_i = a; bus1.data_i = d;
        end else begin
            bus3.MemRead_i = rd; bus3.MemWrite_i = wr; bus3.addr_i = a; bus3.data_i = d;
        end
    endtask

    // Drive one request, hold it until ack, and report what was observed.
    task automatic run_txn(input bit sel1, input stim_t s,
                           output int ack_at, output int stall_mask,
                           output logic err, output logic [31:0] data);
        logic st, ak;
        @(posedge clk); #1;
        drive(sel1, s.rd, s.wr, s.a, s.d);
        ack_at = -1; stall_mask = 0; err = 1'b0; data = 32'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            st = sel1 ? bus1.stall_o : bus3.stall_o;
            ak = sel1 ? bus1.ack_o   : bus3.ack_o;
            if (st) stall_mask |= (1 << k);
            if (ak) begin
                ack_at = k;
                err    = sel1 ? bus1.err_o  : bus3.err_o;
                data   = sel1 ? bus1.data_o : bus3.data_o;
                break;
            end
        end
        @(posedge clk); #1;
        drive(sel1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL reset3 stall: got %b want 0", bus3.stall_o); end
        vectors++; if (bus3.ack_o   !== 1'b0) begin miscompares++; $display("FAIL reset3 ack: got %b want 0", bus3.ack_o); end
        vectors++; if (bus3.err_o   !== 1'b0) begin miscompares++; $display("FAIL reset3 err: got %b want 0", bus3.err_o); end
        vectors++; if (bus3.data_o  !== 32'd0) begin miscompares++; $display("FAIL reset3 data: got %h want 0", bus3.data_o); end
        vectors++; if (bus1.ack_o   !== 1'b0) begin miscompares++; $display("FAIL reset1 ack: got %b want 0", bus1.ack_o); end
        vectors++; if (bus1.data_o  !== 32'd0) begin miscompares++; $display("FAIL reset1 data: got %h want 0", bus1.data_o); end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last[0] = 32'd0;
        mdl_last[1] = 32'd0;
    endtask

    task automatic test_store_load();
        stim_t t [2] = '{'{1'b0, 1'b1, 32'h10, 32'hDEADBEEF},
                         '{1'b1, 1'b0, 32'h10, 32'h0}};
        exp_t e; int ack_at, mask; logic err; logic [31:0] data;
        for (int i = 0; i < 2; i++) begin
            push_expect(1'b0, t[i].rd, t[i].wr, t[i].a, t[i].d);
            run_txn(1'b0, t[i], ack_at, mask, err, data);
            e = sb.pop_front();
            vectors++; if (ack_at !== e.ack_at)   begin miscompares++; $display("FAIL store_load[%0d] ack cycle: got %0d want %0d", i, ack_at, e.ack_at); end
            vectors++; if (mask   !== e.stall_mask) begin miscompares++; $display("FAIL store_load[%0d] stall pattern: got %b want %b", i, mask, e.stall_mask); end
            vectors++; if (err    !== e.err)      begin miscompares++; $display("FAIL store_load[%0d] err: got %b want %b", i, err, e.err); end
            vectors++; if (data   !== e.data)     begin miscompares++; $display("FAIL store_load[%0d] data: got %h want %h", i, data, e.data); end
        end
    endtask

    task automatic test_errors();
        stim_t t [6] = '{'{1'b1, 1'b0, 32'h13, 32'h0},          // misaligned
                         '{1'b1, 1'b0, 32'h80, 32'h0},          // first out-of-range
                         '{1'b1, 1'b1, 32'h10, 32'h0BADF00D},   // read+write conflict
                         '{1'b1, 1'b0, 32'h10, 32'h0},          // word untouched
                         '{1'b0, 1'b1, 32'h7C, 32'hCAFEF00D},   // last valid word
                         '{1'b1, 1'b0, 32'h7C, 32'h0}};
        exp_t e; int ack_at, mask; logic err; logic [31:0] data;
        for (int i = 0; i < 6; i++) begin
            push_expect(1'b0, t[i].rd, t[i].wr, t[i].a, t[i].d);
            run_txn(1'b0, t[i], ack_at, mask, err, data);
            e = sb.pop_front();
            vectors++; if (ack_at !== e.ack_at)   begin miscompares++; $display("FAIL errors[%0d] ack cycle: got %0d want %0d", i, ack_at, e.ack_at); end
            vectors++; if (mask   !== e.stall_mask) begin miscompares++; $display("FAIL errors[%0d] stall pattern: got %b want %b", i, mask, e.stall_mask); end
            vectors++; if (err    !== e.err)      begin miscompares++; $display("FAIL errors[%0d] err: got %b want %b", i, err, e.err); end
            vectors++; if (data   !== e.data)     begin miscompares++; $display("FAIL errors[%0d] data: got %h want %h", i, data, e.data); end
        end
    endtask

    task automatic test_reset_mid_store();
        stim_t t [3] = '{'{1'b0, 1'b1, 32'h04, 32'hA5A5A5A5},
                         '{1'b1, 1'b0, 32'h04, 32'h0},
                         '{1'b1, 1'b0, 32'h04, 32'h0}};
        exp_t e; int ack_at, mask; logic err; logic [31:0] data;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                // Interrupted store: issue it, reset mid-BUSY at T+2.
                @(posedge clk); #1;
                drive(1'b0, 1'b0, 1'b1, 32'h04, 32'h12345678);
                @(negedge clk);
                vectors++; if (bus3.stall_o !== 1'b1) begin miscompares++; $display("FAIL mid_store stall at T: got %b want 1", bus3.stall_o); end
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b0;
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                #1;
                vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL mid_store async stall: got %b want 0", bus3.stall_o); end
                vectors++; if (bus3.ack_o   !== 1'b0) begin miscompares++; $display("FAIL mid_store async ack: got %b want 0", bus3.ack_o); end
                vectors++; if (bus3.data_o  !== 32'd0) begin miscompares++; $display("FAIL mid_store async data: got %h want 0", bus3.data_o); end
                @(negedge clk);
                rst_n = 1'b1;
                mdl_last[0] = 32'd0;
                mdl_last[1] = 32'd0;
            end
            push_expect(1'b0, t[i].rd, t[i].wr, t[i].a, t[i].d);
            run_txn(1'b0, t[i], ack_at, mask, err, data);
            e = sb.pop_front();
            vectors++; if (ack_at !== e.ack_at)   begin miscompares++; $display("FAIL mid_store[%0d] ack cycle: got %0d want %0d", i, ack_at, e.ack_at); end
            vectors++; if (mask   !== e.stall_mask) begin miscompares++; $display("FAIL mid_store[%0d] stall pattern: got %b want %b", i, mask, e.stall_mask); end
            vectors++; if (err    !== e.err)      begin miscompares++; $display("FAIL mid_store[%0d] err: got %b want %b", i, err, e.err); end
            vectors++; if (data   !== e.data)     begin miscompares++; $display("FAIL mid_store[%0d] data: got %h want %h", i, data, e.data); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t [2] = '{'{1'b0, 1'b1, 32'h00, 32'h11111111},
                         '{1'b0, 1'b1, 32'h04, 32'h22222222}};
        logic [5:0] stall_pat = 6'b011011;
        exp_t e; int ack_at, mask, base, acks; logic err; logic [31:0] data;
        for (int i = 0; i < 2; i++) begin
            push_expect(1'b1, t[i].rd, t[i].wr, t[i].a, t[i].d);
            run_txn(1'b1, t[i], ack_at, mask, err, data);
            e = sb.pop_front();
            vectors++; if (ack_at !== e.ack_at)   begin miscompares++; $display("FAIL b2b_pre[%0d] ack cycle: got %0d want %0d", i, ack_at, e.ack_at); end
            vectors++; if (mask   !== e.stall_mask) begin miscompares++; $display("FAIL b2b_pre[%0d] stall pattern: got %b want %b", i, mask, e.stall_mask); end
            vectors++; if (err    !== e.err)      begin miscompares++; $display("FAIL b2b_pre[%0d] err: got %b want %b", i, err, e.err); end
        end
        // Read held continuously; address changes to 0x04 during the first BUSY.
        push_expect(1'b1, 1'b1, 1'b0, 32'h00, 32'h0);
        push_expect(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
        base = 0; acks = 0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h00, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++; if (bus1.stall_o !== stall_pat[k]) begin miscompares++; $display("FAIL b2b stall cycle %0d: got %b want %b", k, bus1.stall_o, stall_pat[k]); end
            if (bus1.ack_o === 1'b1) begin
                acks++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    vectors++; if (k !== base + e.ack_at) begin miscompares++; $display("FAIL b2b ack cycle: got %0d want %0d", k, base + e.ack_at); end
                    vectors++; if (bus1.data_o !== e.data) begin miscompares++; $display("FAIL b2b data: got %h want %h", bus1.data_o, e.data); end
                    vectors++; if (bus1.err_o !== e.err) begin miscompares++; $display("FAIL b2b err: got %b want %b", bus1.err_o, e.err); end
                    base = k + 1;
                end
            end
            if (k == 0) begin
                @(posedge clk); #1;
                bus1.addr_i = 32'h04;
                bus1.data_i = 32'hFFFFFFFF;
            end
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vectors++; if (acks !== 2) begin miscompares++; $display("FAIL b2b ack count: got %0d want 2", acks); end
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_reset_mid_store();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
